// File: rtl/fpres_stage.sv
// fpres_stage: FP result register, run/stall handshake and status register with trap request
module fpres_stage #(
  parameter logic [4:0] EN_RESET = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        unit_stall,
  input  logic [31:0] unit_z,
  input  logic [4:0]  unit_flags,
  output logic        stall,
  output logic [31:0] z,
  output logic        z_valid,
  input  logic        fsr_we,
  input  logic [9:0]  fsr_wdata,
  output logic [14:0] fsr,
  output logic        trap,
  input  logic        trap_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, TRAP} state_t;
  state_t state, state_nx;
  logic [4:0] en, cause, sticky;
  logic capture, idle_run;
  assign idle_run = (state == IDLE) & run;
  assign capture = (idle_run | (state == BUSY)) & ~unit_stall;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state; the trap decision uses the enables in effect before the edge
  always_comb
    state_nx = capture ? ((|(unit_flags & en)) ? TRAP : IDLE) :
               idle_run ? BUSY :
               ((state == TRAP) & trap_ack) ? IDLE : state;
  // handshake and trap outputs
  always_comb begin
    stall = (idle_run & unit_stall) | ((state == BUSY) & unit_stall) | ((state == TRAP) & run);
    trap = state == TRAP;
  end
  // result and status registers; a software write merges with same-edge capture flags
  always_ff @(posedge clk)
    if (rst) begin
      z <= '0;
      z_valid <= 1'b0;
      cause <= '0;
      sticky <= '0;
      en <= EN_RESET;
    end else begin
      z_valid <= capture;
      if (capture) z <= unit_z;
      if (capture) cause <= unit_flags;
      if (fsr_we) en <= fsr_wdata[9:5];
      sticky <= (fsr_we ? fsr_wdata[4:0] : sticky) | (capture ? unit_flags : 5'b0);
    end
  assign fsr = {en, cause, sticky};
endmodule

// File: tb/tb_fpres_stage.sv
// tb_fpres_stage: directed scoreboard bench for fpres_stage with an int-to-float unit stub
module tb_fpres_stage;
  logic clk = 0, rst = 1, run = 0, unit_stall = 0, fsr_we = 0, trap_ack = 0;
  logic [31:0] ux = 0, unit_z, z;
  logic [4:0] unit_flags;
  logic [9:0] fsr_wdata = 0;
  logic [14:0] fsr;
  logic stall, z_valid, trap;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [31:0] z; logic [14:0] f;} exp_t;
  exp_t q[$];

  fpres_stage dut (.clk(clk), .rst(rst), .run(run), .unit_stall(unit_stall), .unit_z(unit_z),
    .unit_flags(unit_flags), .stall(stall), .z(z), .z_valid(z_valid), .fsr_we(fsr_we),
    .fsr_wdata(fsr_wdata), .fsr(fsr), .trap(trap), .trap_ack(trap_ack));

  always #5 clk = ~clk;

  function automatic logic [36:0] fpflt(input logic [31:0] x);
    logic s, g, st, up;
    logic [31:0] m;
    logic [24:0] r;
    int e;
    if (x == 0) return '0;
    s = x[31];
    m = s ? -x : x;
    e = 31;
    while (!m[31]) begin m = m << 1; e--; end
    g = m[7];
    st = |m[6:0];
    up = g & (st | m[8]);
    r = {1'b0, m[31:8]} + {24'b0, up};
    if (r[24]) begin e++; r = r >> 1; end
    return {s, 8'(e + 127), r[22:0], 4'b0, g | st};
  endfunction

  always_comb {unit_z, unit_flags} = fpflt(ux);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ez, input logic [14:0] ef);
    q.push_back({ez, ef});
  endtask

  always @(negedge clk)
    if (z_valid) begin
      if (q.size() == 0) chk("unexpected_z_valid", 32'(z_valid), 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_z", z, e.z);
        chk("sb_fsr", 32'(fsr), 32'(e.f));
      end
    end

  initial begin
    #1;
    chk("stall_in_reset", 32'(stall), 0);
    tick;
    tick;
    rst = 0;
    chk("rst_z", z, 0);
    chk("rst_zv", 32'(z_valid), 0);
    chk("rst_fsr", 32'(fsr), 0);
    chk("rst_trap", 32'(trap), 0);
    ux = 32'h1; run = 1; push(32'h3F800000, 15'h0000);
    #1 chk("flt1_stall", 32'(stall), 0);
    tick; run = 0;
    chk("flt1_zv", 32'(z_valid), 1);
    tick;
    chk("flt1_zv_pulse", 32'(z_valid), 0);
    chk("flt1_hold", z, 32'h3F800000);
    ux = 32'h01000001; run = 1; push(32'h4B800000, 15'h0021);
    tick;
    ux = 32'h2; push(32'h40000000, 15'h0001);
    tick; run = 0;
    chk("flt2_fsr", 32'(fsr), 32'h0001);
    tick;
    ux = 32'h3; run = 1; unit_stall = 1;
    #1 chk("busy_stall0", 32'(stall), 1);
    tick; run = 0;
    chk("busy_stall1", 32'(stall), 1);
    chk("busy_zv1", 32'(z_valid), 0);
    tick; run = 1;
    #1 chk("busy_stall2", 32'(stall), 1);
    chk("busy_zv2", 32'(z_valid), 0);
    tick; run = 0; unit_stall = 0; push(32'h40400000, 15'h0001);
    #1 chk("busy_stall3", 32'(stall), 0);
    chk("busy_zv3", 32'(z_valid), 0);
    tick;
    chk("busy_zv4", 32'(z_valid), 1);
    tick;
    chk("busy_no_second", 32'(z_valid), 0);
    fsr_we = 1; fsr_wdata = 10'b00001_00000;
    tick; fsr_we = 0;
    chk("we_fsr", 32'(fsr), 32'h0400);
    chk("we_no_trap", 32'(trap), 0);
    ux = 32'h01000001; run = 1; push(32'h4B800000, 15'h0421);
    tick; run = 0;
    chk("trap_set", 32'(trap), 1);
    tick;
    chk("trap_held", 32'(trap), 1);
    ux = 32'h1; run = 1;
    #1 chk("trap_run_stall", 32'(stall), 1);
    tick; run = 0;
    chk("trap_no_capture", 32'(z_valid), 0);
    chk("trap_z_hold", z, 32'h4B800000);
    trap_ack = 1;
    tick; trap_ack = 0;
    chk("trap_ack", 32'(trap), 0);
    run = 1; push(32'h3F800000, 15'h0401);
    #1 chk("rerun_stall", 32'(stall), 0);
    tick; run = 0;
    chk("rerun_no_trap", 32'(trap), 0);
    ux = 32'h01000001; run = 1; fsr_we = 1; fsr_wdata = 10'h000; push(32'h4B800000, 15'h0021);
    tick; run = 0; fsr_we = 0;
    chk("merge_fsr", 32'(fsr), 32'h0021);
    chk("merge_trap_old_en", 32'(trap), 1);
    trap_ack = 1;
    tick; trap_ack = 0;
    ux = 32'h3; run = 1; unit_stall = 1;
    tick; run = 0; rst = 1;
    tick; rst = 0;
    chk("rstbusy_fsr", 32'(fsr), 0);
    chk("rstbusy_z", z, 0);
    chk("rstbusy_trap", 32'(trap), 0);
    chk("rstbusy_stall", 32'(stall), 0);
    unit_stall = 0;
    tick;
    chk("rstbusy_no_zv", 32'(z_valid), 0);
    tick;
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpres_stage.md
Name: fpres_stage

Overview:
- Result/status stage directly downstream of the FP execution units (fpflt and siblings). Consumes each unit's z[31:0] and flags[4:0] when the unit completes.
- Registers the result for writeback and sequences the run/stall handshake for multi-cycle units.
- Maintains the FP status register: sticky flags, cause, and trap enables. Raises a trap request when an enabled exception occurs.

Parameters:
- EN_RESET, 5'b00000, reset value of the trap-enable field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- run  in  1  start pulse, shared with the execution unit
- unit_stall  in  1  execution unit stall; high = result not ready
- unit_z  in  32  execution unit result
- unit_flags  in  5  execution unit flags {v,i,o,u,x}
- stall  out  1  pipeline stall (combinational)
- z  out  32  registered result
- z_valid  out  1  one-cycle pulse: z updated
- fsr_we  in  1  software write of status register
- fsr_wdata  in  10  {enables[4:0], sticky[4:0]}
- fsr  out  15  {enables[4:0], cause[4:0], sticky[4:0]}
- trap  out  1  trap request, level
- trap_ack  in  1  trap acknowledge

Behaviour:
- Single clock. rst is synchronous and active-high: on any edge with rst=1, all state resets.
- Reset values:
  - state=IDLE, z=0, z_valid=0, cause=0, sticky=0, enables=EN_RESET, trap=0.
  - An in-flight unit result is discarded. stall is combinational and reads 0 while in reset with run=0.
- States: IDLE, BUSY, TRAP.
- "capture" is defined as ((IDLE & run) | BUSY) & ~unit_stall. On the edge where capture holds:
  - z <= unit_z
  - z_valid <= 1 for exactly one cycle
  - cause <= unit_flags
  - sticky <= sticky | unit_flags
- Transitions:
  - IDLE & run & unit_stall -> BUSY.
  - IDLE & run & ~unit_stall -> capture. Go to TRAP if (unit_flags & enables) != 0, else stay IDLE.
  - BUSY & unit_stall -> BUSY.
  - BUSY & ~unit_stall -> capture. Same TRAP/IDLE decision as above.
  - TRAP: trap=1. Leave to IDLE on trap_ack. Result and status are already updated on trap entry.
- stall = (IDLE & run & unit_stall) | (BUSY & unit_stall) | (TRAP & run).
- Latency: single-cycle unit (fpflt, unit_stall=0) gives z_valid one cycle after run. An N-cycle stall gives z_valid at run+N+1.
- run in BUSY: no effect, protocol error; no second operation is started.
- run in TRAP: ignored and stalled. It must be re-presented after trap_ack.
- trap_ack in IDLE/BUSY: no effect.
- fsr_we:
  - enables <= fsr_wdata[9:5]; sticky <= fsr_wdata[4:0]; cause unchanged.
  - Same edge as a capture: sticky <= fsr_wdata[4:0] | unit_flags and cause <= unit_flags. No flag is lost.
  - Writing enables does not itself raise trap. Trap is evaluated only at capture, against the enables value in effect before the edge.
- Flags bit order throughout: [4]=v invalid, [3]=i div-by-zero, [2]=o overflow, [1]=u underflow, [0]=x inexact.
- z holds its value between captures. z_valid is 0 in all non-capture cycles.

Test Plan:
- Reset, then run with x=0x00000001 via fpflt -> next cycle z=0x3F800000, z_valid=1 for one cycle, fsr=15'h0, stall=0 throughout.
- x=0x01000001 via fpflt -> z=0x4B800000, cause=5'b00001, sticky=5'b00001. Follow with x=2 -> z=0x40000000, cause=0, sticky still 5'b00001.
- Stub unit holding unit_stall=1 for 3 cycles after run -> stall=1 for those 3 cycles, state BUSY, z_valid at cycle run+4. A run pulse in BUSY starts nothing.
- fsr_we with fsr_wdata=10'b00001_00000, then an inexact conversion -> trap=1 held. A run while trapped gives stall=1 and no capture. trap_ack -> IDLE, and the re-presented run completes normally.
- fsr_we with wdata=10'h000 on the same edge as an inexact capture -> sticky=5'b00001, cause=5'b00001.
- Assert rst during BUSY -> next cycle state IDLE, fsr={EN_RESET,0,0}, z=0, trap=0, no z_valid when unit_stall later drops.
